// File: rtl/instruction_fetch_stage.sv
// instruction_fetch_stage: RISC-V program counter and IF/ID pipeline register.
// Drives the fetch address and captures {pc, instruction, valid} for decode.
//
// Ports:
//   clk                 rising-edge clock
//   reset               synchronous, active-low reset
//   stall               hold pc and the IF/ID register
//   flush               turn the next IF/ID capture into a bubble
//   branch_taken        redirect request from execute
//   branch_target       redirect byte address
//   Instruction_address fetch byte address (the pc register itself)
//   Instruction         little-endian word returned for Instruction_address
//   if_id_pc            pc of the captured instruction
//   if_id_instruction   captured instruction word
//   if_id_valid         captured word is real, not a bubble
//   misalign_err        sticky misaligned-redirect flag
//   fetch_count         number of valid captures since reset (wraps)
//
// Build option: define FETCH_MISALIGN_TRAP_EN to trap misaligned redirects
// (pc held, misalign_err set and sticky until reset). Without it, the low two
// target bits are dropped and misalign_err is tied to 0.

module instruction_fetch_stage #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        branch_taken,
  input  logic [63:0] branch_target,
  output logic [63:0] Instruction_address,
  input  logic [31:0] Instruction,
  output logic [63:0] if_id_pc,
  output logic [31:0] if_id_instruction,
  output logic        if_id_valid,
  output logic        misalign_err,
  output logic [31:0] fetch_count
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [63:0] pc_q, pc_d;
  logic [63:0] ifid_pc_q, ifid_pc_d;
  logic [31:0] ifid_ins_q, ifid_ins_d;
  logic        ifid_vld_q, ifid_vld_d;
  logic [31:0] cnt_q, cnt_d;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic        err_q, err_d;
  logic        tgt_misaligned;

  assign tgt_misaligned = |branch_target[1:0];
`endif

  always_comb begin
    pc_d       = pc_q;
    ifid_pc_d  = ifid_pc_q;
    ifid_ins_d = ifid_ins_q;
    ifid_vld_d = ifid_vld_q;
    cnt_d      = cnt_q;
`ifdef FETCH_MISALIGN_TRAP_EN
    err_d      = err_q;
`endif
    if (branch_taken) begin
      // Wrong-path word in flight is dropped; stall is irrelevant here.
      ifid_vld_d = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      if (tgt_misaligned) begin
        err_d = 1'b1;
      end else begin
        pc_d = branch_target;
      end
`else
      pc_d = branch_target & ~64'd3;
`endif
    end else if (stall) begin
      if (flush) begin
        ifid_vld_d = 1'b0;
      end
    end else begin
      ifid_pc_d  = pc_q;
      ifid_ins_d = Instruction;
      ifid_vld_d = ~flush;
      pc_d       = pc_q + 64'd4;
      if (!flush) begin
        cnt_d = cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q       <= RESET_PC;
      ifid_pc_q  <= '0;
      ifid_ins_q <= NOP;
      ifid_vld_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      pc_q       <= pc_d;
      ifid_pc_q  <= ifid_pc_d;
      ifid_ins_q <= ifid_ins_d;
      ifid_vld_q <= ifid_vld_d;
      cnt_q      <= cnt_d;
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign misalign_err = err_q;
`else
  assign misalign_err = 1'b0;
`endif

  assign Instruction_address = pc_q;
  assign if_id_pc            = ifid_pc_q;
  assign if_id_instruction   = ifid_ins_q;
  assign if_id_valid         = ifid_vld_q;
  assign fetch_count         = cnt_q;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// tb_instruction_fetch_stage: directed test of the fetch stage with a
// behavioural model compared every cycle plus literal expectations.

module tb_instruction_fetch_stage;

  logic        clk = 1'b0;
  logic        reset, stall, flush, bt;
  logic [63:0] tgt;
  logic [63:0] iaddr;
  logic [31:0] ins;
  logic [63:0] ifpc;
  logic [31:0] ifins;
  logic        ifvld, err;
  logic [31:0] cnt;

  logic        rst1;
  logic [63:0] iaddr1, ifpc1;
  logic [31:0] ins1, ifins1, cnt1;
  logic        ifvld1, err1;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] imem(input logic [63:0] a);
    case (a)
      64'd0:   return 32'h0285_3483;
      64'd4:   return 32'h009A_84B3;
      64'd8:   return 32'h0014_8493;
      64'd12:  return 32'h0295_3423;
      default: return a[31:0] ^ 32'hDEAD_0000;
    endcase
  endfunction

  assign ins  = imem(iaddr);
  assign ins1 = imem(iaddr1);

  instruction_fetch_stage #(.RESET_PC(64'h0)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .branch_taken(bt), .branch_target(tgt),
    .Instruction_address(iaddr), .Instruction(ins),
    .if_id_pc(ifpc), .if_id_instruction(ifins), .if_id_valid(ifvld),
    .misalign_err(err), .fetch_count(cnt)
  );

  instruction_fetch_stage #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) dut_wrap (
    .clk(clk), .reset(rst1), .stall(1'b0), .flush(1'b0),
    .branch_taken(1'b0), .branch_target(64'h0),
    .Instruction_address(iaddr1), .Instruction(ins1),
    .if_id_pc(ifpc1), .if_id_instruction(ifins1), .if_id_valid(ifvld1),
    .misalign_err(err1), .fetch_count(cnt1)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Model: plain statement of the per-edge rules.
  logic [63:0] m_pc, m_ifpc;
  logic [31:0] m_ins, m_cnt;
  logic        m_vld, m_err;

  always @(posedge clk) begin
    if (!reset) begin
      m_pc <= 64'd0; m_ifpc <= 64'd0; m_ins <= 32'h13;
      m_vld <= 1'b0; m_err <= 1'b0; m_cnt <= 32'd0;
    end else if (bt) begin
      m_vld <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      if (tgt % 4 != 0) m_err <= 1'b1;
      else m_pc <= tgt;
`else
      m_pc <= tgt - (tgt % 4);
`endif
    end else if (stall) begin
      if (flush) m_vld <= 1'b0;
    end else begin
      m_ifpc <= m_pc;
      m_ins  <= imem(m_pc);
      m_vld  <= !flush;
      m_pc   <= m_pc + 64'd4;
      if (!flush) m_cnt <= m_cnt + 32'd1;
    end
  end

  always @(posedge clk) begin
    #1;
    chk("m_pc", iaddr, m_pc);
    chk("m_ifpc", ifpc, m_ifpc);
    chk("m_ins", {32'd0, ifins}, {32'd0, m_ins});
    chk("m_vld", {63'd0, ifvld}, {63'd0, m_vld});
    chk("m_err", {63'd0, err}, {63'd0, m_err});
    chk("m_cnt", {32'd0, cnt}, {32'd0, m_cnt});
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  logic [31:0] prog [4];

  initial begin
    prog[0] = 32'h0285_3483;
    prog[1] = 32'h009A_84B3;
    prog[2] = 32'h0014_8493;
    prog[3] = 32'h0295_3423;
    reset = 1'b0; rst1 = 1'b0; stall = 1'b0; flush = 1'b0;
    bt = 1'b0; tgt = 64'd0;

    // Reset then run
    step(); step();
    chk("rst_pc", iaddr, 64'd0);
    chk("rst_ins", {32'd0, ifins}, 64'h13);
    chk("rst_vld", {63'd0, ifvld}, 64'd0);
    chk("rst_cnt", {32'd0, cnt}, 64'd0);
    chk("rst_err", {63'd0, err}, 64'd0);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("run_ins", {32'd0, ifins}, {32'd0, prog[i]});
      chk("run_pc", ifpc, 64'(4 * i));
      chk("run_vld", {63'd0, ifvld}, 64'd1);
    end
    chk("run_cnt", {32'd0, cnt}, 64'd4);
    chk("run_addr", iaddr, 64'd16);

    // Stall at pc=8
    reset = 1'b0; step(); reset = 1'b1;
    step(); step();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stl_addr", iaddr, 64'd8);
      chk("stl_ifpc", ifpc, 64'd4);
      chk("stl_ins", {32'd0, ifins}, 64'h009A_84B3);
      chk("stl_vld", {63'd0, ifvld}, 64'd1);
      chk("stl_cnt", {32'd0, cnt}, 64'd2);
    end
    stall = 1'b0;
    step();
    chk("stl_rel_pc", ifpc, 64'd8);
    chk("stl_rel_ins", {32'd0, ifins}, 64'h0014_8493);

    // Flush without stall: bubble, count frozen
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("fl_vld", {63'd0, ifvld}, 64'd0);
    chk("fl_cnt", {32'd0, cnt}, 64'd3);
    chk("fl_addr", iaddr, 64'd16);

    // Flush with stall at pc=4
    reset = 1'b0; step(); reset = 1'b1;
    step();
    flush = 1'b1; stall = 1'b1;
    step();
    flush = 1'b0; stall = 1'b0;
    chk("fs_vld", {63'd0, ifvld}, 64'd0);
    chk("fs_addr", iaddr, 64'd4);
    step();
    chk("fs_ins", {32'd0, ifins}, 64'h009A_84B3);
    chk("fs_vld2", {63'd0, ifvld}, 64'd1);

    // Branch over stall at pc=12
    reset = 1'b0; step(); reset = 1'b1;
    step(); step(); step();
    chk("br_pre", iaddr, 64'd12);
    bt = 1'b1; tgt = 64'd4; stall = 1'b1;
    step();
    bt = 1'b0; stall = 1'b0;
    chk("br_addr", iaddr, 64'd4);
    chk("br_vld", {63'd0, ifvld}, 64'd0);
    chk("br_cnt", {32'd0, cnt}, 64'd3);
    step();
    chk("br_ifpc", ifpc, 64'd4);
    chk("br_ins", {32'd0, ifins}, 64'h009A_84B3);

    // Misaligned redirect from pc=8
    bt = 1'b1; tgt = 64'd6;
    step();
    bt = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("mis_addr", iaddr, 64'd8);
    chk("mis_err", {63'd0, err}, 64'd1);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("mis_sticky", {63'd0, err}, 64'd1);
    end
`else
    chk("mis_addr", iaddr, 64'd4);
    chk("mis_err", {63'd0, err}, 64'd0);
`endif
    reset = 1'b0; step(); reset = 1'b1;
    chk("mis_rst", {63'd0, err}, 64'd0);

    // PC wrap
    rst1 = 1'b1;
    step();
    chk("wrap_pc", iaddr1, 64'd0);
    chk("wrap_ifpc", ifpc1, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap_vld", {63'd0, ifvld1}, 64'd1);
    chk("wrap_cnt", {32'd0, cnt1}, 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
